fb_fetch: RTL and testbench



---
 rtl/fb_fetch_pkg.sv | 38 +++
 rtl/fb_fetch_fifo.sv | 81 ++++++++
 rtl/fb_fetch.sv | 196 +++++++++++++++++++
 tb/tb_fb_fetch.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fb_fetch_pkg.sv
// fb_fetch_pkg: shared definitions for the frame-buffer fetch engine.
// Holds the fetch FSM state encoding, the FIFO entry layout (33 bits:
// start-of-frame flag on top of a 32-bit pixel word) and the RGB field
// offsets inside a memory word.
package fb_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_REQ   = 2'd2,
        ST_DATA  = 2'd3
    } fetch_state_e;

    // FIFO entry: {sof, pixel[31:0]}
    localparam int unsigned FIFO_W  = 33;
    localparam int unsigned PIX_W   = 32;
    localparam int unsigned SOF_BIT = 32;

    // Pixel word layout {8'h0, R, G, B}
    localparam int unsigned B_LSB = 0;
    localparam int unsigned G_LSB = 8;
    localparam int unsigned R_LSB = 16;

    // Builds a FIFO entry; the top byte of the pixel word is always zero.
    function automatic logic [FIFO_W-1:0] pack_entry(input logic       sof,
                                                     input logic [7:0] r,
                                                     input logic [7:0] g,
                                                     input logic [7:0] b);
        logic [FIFO_W-1:0] e;
        e              = '0;
        e[SOF_BIT]     = sof;
        e[R_LSB +: 8]  = r;
        e[G_LSB +: 8]  = g;
        e[B_LSB +: 8]  = b;
        return e;
    endfunction

endpackage

// File: rtl/fb_fetch_fifo.sv
// fb_fetch_fifo: synchronous first-word-fall-through FIFO.
// Storage RAM plus a registered head entry. A write at edge N becomes
// visible on dout_o (with empty_o low) after edge N+1; a pop at edge N
// presents the next stored entry right after edge N.
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   wr_en_i, din_i   push one entry
//   rd_en_i          pop head entry (ignored while empty)
//   dout_o           head entry (registered, zero after reset)
//   empty_o          no head entry available
//   count_o          total entries held (RAM + head)
module fb_fetch_fifo
    import fb_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = FIFO_W,
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             wr_en_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             rd_en_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CNT_W-1:0] ram_cnt_q;
    logic [CNT_W-1:0] ram_cnt_d;
    logic [WIDTH-1:0] head_q;
    logic             head_vld_q;
    logic             head_vld_d;
    logic             pop;
    logic             load;

    // The head register refills from RAM whenever it is empty or being
    // popped; an entry written this cycle is not yet in ram_cnt_q, which
    // gives the one-cycle write-to-visible latency.
    always_comb begin
        pop        = rd_en_i && head_vld_q;
        load       = (!head_vld_q || pop) && (ram_cnt_q != '0);
        ram_cnt_d  = ram_cnt_q + CNT_W'(wr_en_i) - CNT_W'(load);
        head_vld_d = load || (head_vld_q && !pop);
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ram_cnt_q  <= '0;
            head_q     <= '0;
            head_vld_q <= 1'b0;
        end else begin
            if (wr_en_i) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (load) begin
                head_q   <= mem_q[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            ram_cnt_q  <= ram_cnt_d;
            head_vld_q <= head_vld_d;
        end
    end

    assign dout_o  = head_q;
    assign empty_o = !head_vld_q;
    assign count_o = ram_cnt_q + CNT_W'(head_vld_q);

endmodule

// File: rtl/fb_fetch.sv
// fb_fetch: frame-buffer fetch engine feeding the FRC pixel port.
// Walks the frame buffer once per triggered frame with fixed-length read
// bursts (optionally interleaving upper/lower half rows for dual-scan
// panels), buffers the returned words in a FWFT FIFO and presents them
// with an empty/read-enable handshake.
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   trigger              frame enable, sampled in IDLE only
//   mem_req, mem_addr    burst request and start word address
//   mem_gnt              request accepted
//   mem_valid, mem_data  returned data beat {8'h0,R,G,B}
//   pix_data, pix_sof    head pixel and its start-of-frame flag
//   pix_empty, pix_re    FIFO empty / pop
//   busy                 frame fetch in progress
//   underrun             sticky: pop attempted while empty
module fb_fetch
    import fb_fetch_pkg::*;
#(
    parameter int unsigned       H_PIX      = 640,
    parameter int unsigned       V_LINES    = 480,
    parameter int unsigned       DUAL_SCAN  = 1,
    parameter int unsigned       ADDR_W     = 24,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int unsigned       BURST      = 16,
    parameter int unsigned       FIFO_DEPTH = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trigger,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_valid,
    input  logic [31:0]       mem_data,
    output logic [31:0]       pix_data,
    output logic              pix_sof,
    output logic              pix_empty,
    input  logic              pix_re,
    output logic              busy,
    output logic              underrun
);

    localparam int unsigned NBURST = H_PIX / BURST;
    localparam int unsigned NLINE  = (DUAL_SCAN != 0) ? (V_LINES / 2) : V_LINES;
    localparam int unsigned B_W    = (NBURST > 1) ? $clog2(NBURST) : 1;
    localparam int unsigned L_W    = (NLINE > 1) ? $clog2(NLINE) : 1;
    localparam int unsigned BT_W   = (BURST > 1) ? $clog2(BURST) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;

    localparam logic [ADDR_W-1:0] H_STEP     = ADDR_W'(H_PIX);
    localparam logic [ADDR_W-1:0] BURST_STEP = ADDR_W'(BURST);
    localparam logic [ADDR_W-1:0] HALF_OFS   = ADDR_W'((V_LINES / 2) * H_PIX);

    fetch_state_e      state_q;
    logic [B_W-1:0]    b_q;
    logic [L_W-1:0]    l_q;
    logic              phase_q;
    logic [BT_W-1:0]   beat_q;
    logic              sof_q;
    logic              mem_req_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              busy_q;
    logic              underrun_q;

    logic [ADDR_W-1:0] addr_d;
    logic              room;
    logic              beat_last;
    logic              col_adv;
    logic              frame_end;
    logic              fifo_wr;
    logic [FIFO_W-1:0] fifo_din;
    logic [FIFO_W-1:0] fifo_dout;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_cnt;
    logic              unused_hi;

    // Burst start address; the lower-half burst of a dual-scan pair sits
    // half a frame further on. Wraps modulo 2^ADDR_W.
    always_comb begin
        addr_d = BASE_ADDR + ADDR_W'(l_q) * H_STEP + ADDR_W'(b_q) * BURST_STEP;
        if ((DUAL_SCAN != 0) && phase_q) begin
            addr_d = addr_d + HALF_OFS;
        end
    end

    always_comb begin
        room      = (fifo_cnt <= CNT_W'(FIFO_DEPTH - BURST));
        beat_last = (beat_q == BT_W'(BURST - 1));
        // In dual-scan the column only moves on after the lower-half burst.
        col_adv   = (DUAL_SCAN != 0) ? phase_q : 1'b1;
        frame_end = col_adv && (b_q == B_W'(NBURST - 1)) && (l_q == L_W'(NLINE - 1));
        fifo_wr   = (state_q == ST_DATA) && mem_valid;
        fifo_din  = pack_entry(sof_q, mem_data[R_LSB +: 8], mem_data[G_LSB +: 8],
                               mem_data[B_LSB +: 8]);
    end

    assign unused_hi = ^mem_data[31:24];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            b_q        <= '0;
            l_q        <= '0;
            phase_q    <= 1'b0;
            beat_q     <= '0;
            sof_q      <= 1'b0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (trigger) begin
                        b_q     <= '0;
                        l_q     <= '0;
                        phase_q <= 1'b0;
                        sof_q   <= 1'b1;
                        busy_q  <= 1'b1;
                        state_q <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (room) begin
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= addr_d;
                        state_q    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_gnt) begin
                        mem_req_q <= 1'b0;
                        beat_q    <= '0;
                        state_q   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (mem_valid) begin
                        sof_q  <= 1'b0;
                        beat_q <= beat_q + BT_W'(1);
                        if (beat_last) begin
                            if (DUAL_SCAN != 0) begin
                                phase_q <= !phase_q;
                            end
                            if (col_adv) begin
                                if (b_q == B_W'(NBURST - 1)) begin
                                    b_q <= '0;
                                    l_q <= l_q + L_W'(1);
                                end else begin
                                    b_q <= b_q + B_W'(1);
                                end
                            end
                            if (frame_end) begin
                                busy_q  <= 1'b0;
                                state_q <= ST_IDLE;
                            end else begin
                                state_q <= ST_CHECK;
                            end
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            underrun_q <= 1'b0;
        end else if (pix_re && fifo_empty) begin
            underrun_q <= 1'b1;
        end
    end

    fb_fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FIFO_W)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rst),
        .wr_en_i (fifo_wr),
        .din_i   (fifo_din),
        .rd_en_i (pix_re),
        .dout_o  (fifo_dout),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign pix_data  = fifo_dout[PIX_W-1:0];
    assign pix_sof   = fifo_dout[SOF_BIT];
    assign pix_empty = fifo_empty;
    assign busy      = busy_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_fb_fetch.sv
// Bench for fb_fetch: a dual-scan instance driven by a randomised memory
// responder and pixel consumer, plus a linear-scan instance with an ideal
// responder. Expected addresses/pixels come from a frame-level model.
module tb_fb_fetch;

    localparam int unsigned H   = 32;
    localparam int unsigned V   = 4;
    localparam int unsigned BR  = 16;
    localparam logic [23:0] BASE = 24'h100;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // dual-scan DUT
    logic        trigger = 1'b0;
    logic        mem_req;
    logic [23:0] mem_addr;
    logic        mem_gnt = 1'b0;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_data = '0;
    logic [31:0] pix_data;
    logic        pix_sof;
    logic        pix_empty;
    logic        pix_re = 1'b0;
    logic        busy;
    logic        underrun;

    // linear DUT
    logic        l_trig = 1'b0;
    logic        l_req;
    logic [23:0] l_addr;
    logic        l_gnt = 1'b0;
    logic        l_valid = 1'b0;
    logic [31:0] l_data = '0;
    logic [31:0] l_pix;
    logic        l_sof;
    logic        l_empty;
    logic        l_re = 1'b1;
    logic        l_busy;
    logic        l_underrun;

    fb_fetch #(
        .H_PIX(H), .V_LINES(V), .DUAL_SCAN(1), .ADDR_W(24), .BASE_ADDR(BASE),
        .BURST(BR), .FIFO_DEPTH(32)
    ) u_dut (
        .clk(clk), .rst(rst), .trigger(trigger), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_gnt(mem_gnt), .mem_valid(mem_valid), .mem_data(mem_data),
        .pix_data(pix_data), .pix_sof(pix_sof), .pix_empty(pix_empty), .pix_re(pix_re),
        .busy(busy), .underrun(underrun)
    );

    fb_fetch #(
        .H_PIX(H), .V_LINES(V), .DUAL_SCAN(0), .ADDR_W(24), .BASE_ADDR(BASE),
        .BURST(BR), .FIFO_DEPTH(64)
    ) u_lin (
        .clk(clk), .rst(rst), .trigger(l_trig), .mem_req(l_req), .mem_addr(l_addr),
        .mem_gnt(l_gnt), .mem_valid(l_valid), .mem_data(l_data),
        .pix_data(l_pix), .pix_sof(l_sof), .pix_empty(l_empty), .pix_re(l_re),
        .busy(l_busy), .underrun(l_underrun)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory contents: a scrambled function of the word address with a
    // non-zero top byte so the zeroing of bits [31:24] is visible.
    function automatic logic [31:0] memword(input logic [23:0] a);
        return (32'(a) * 32'h9E3779B1) ^ 32'hC3000000 ^ {8'h00, a};
    endfunction

    function automatic logic [32:0] exp_pix(input logic sof, input logic [23:0] a);
        logic [31:0] w;
        w = memword(a);
        return {sof, 8'h00, w[23:0]};
    endfunction

    // Reference model for the dual-scan instance.
    logic [23:0] exp_addr_q[$];
    logic [32:0] exp_pix_q[$];
    int          frames_pushed = 0;

    task automatic push_frame();
        logic [23:0] a;
        frames_pushed++;
        for (int unsigned l = 0; l < V / 2; l++)
            for (int unsigned b = 0; b < H / BR; b++)
                for (int unsigned ph = 0; ph < 2; ph++) begin
                    a = 24'(BASE + (l + ph * (V / 2)) * H + b * BR);
                    exp_addr_q.push_back(a);
                    for (int unsigned w = 0; w < BR; w++)
                        exp_pix_q.push_back(exp_pix(l == 0 && b == 0 && ph == 0 && w == 0,
                                                    24'(a + w)));
                end
    endtask

    // Dual-scan memory responder.
    int          pend = 0;
    int          gnt_delay = 0;
    int          req_wait = 0;
    int          req_count = 0;
    int          beats_done = 0;
    bit          req_active = 0;
    bit          gap_en = 0;
    bit          spur_en = 0;
    logic [23:0] req_addr = '0;
    logic [23:0] cur_addr = '0;

    initial begin
        forever begin
            @(negedge clk);
            mem_gnt   = 1'b0;
            mem_valid = 1'b0;
            if (!rst) begin
                pend       = 0;
                req_active = 0;
                req_wait   = 0;
            end else if (pend > 0) begin
                if (!gap_en || $urandom_range(0, 2) != 0) begin
                    mem_valid = 1'b1;
                    mem_data  = memword(cur_addr);
                    cur_addr  = 24'(cur_addr + 24'd1);
                    pend--;
                    beats_done++;
                end
            end else if (mem_req) begin
                if (!req_active) begin
                    req_active = 1;
                    req_addr   = mem_addr;
                    req_wait   = 0;
                    req_count++;
                    if (exp_addr_q.size() == 0) push_frame();
                    chk("req_addr", 64'(mem_addr), 64'(exp_addr_q.pop_front()));
                end else begin
                    chk("addr_stable", 64'(mem_addr), 64'(req_addr));
                end
                if (req_wait >= gnt_delay) begin
                    mem_gnt    = 1'b1;
                    pend       = BR;
                    cur_addr   = req_addr;
                    beats_done = 0;
                    req_active = 0;
                end else begin
                    req_wait++;
                end
            end else if (spur_en && $urandom_range(0, 3) == 0) begin
                mem_valid = 1'b1;
                mem_data  = 32'hDEADBEEF;
            end
        end
    end

    // Dual-scan pixel consumer: 0 off, 1 pop when available, 2 random, 3 counted.
    int cons_mode = 0;
    int pops_left = 0;

    initial begin
        logic [32:0] e;
        bit take;
        forever begin
            @(negedge clk);
            pix_re = 1'b0;
            if (rst && !pix_empty && cons_mode != 0) begin
                take = (cons_mode == 1) || (cons_mode == 2 && $urandom_range(0, 1) == 1) ||
                       (cons_mode == 3 && pops_left > 0);
                if (take) begin
                    pix_re = 1'b1;
                    if (cons_mode == 3) pops_left--;
                    chk("pix_avail", 64'(exp_pix_q.size() != 0), 64'(1));
                    if (exp_pix_q.size() != 0) begin
                        e = exp_pix_q.pop_front();
                        chk("pix_data", 64'(pix_data), 64'(e[31:0]));
                        chk("pix_sof", 64'(pix_sof), 64'(e[32]));
                    end
                end
            end
        end
    end

    // Linear instance: ideal responder and always-ready consumer, logged.
    logic [23:0] lin_addr_q[$];
    logic [32:0] lin_pix_q[$];
    int          lpend = 0;
    logic [23:0] lcur = '0;

    initial begin
        forever begin
            @(negedge clk);
            l_gnt   = 1'b0;
            l_valid = 1'b0;
            if (!rst) begin
                lpend = 0;
            end else if (lpend > 0) begin
                l_valid = 1'b1;
                l_data  = memword(lcur);
                lcur    = 24'(lcur + 24'd1);
                lpend--;
            end else if (l_req) begin
                l_gnt = 1'b1;
                lin_addr_q.push_back(l_addr);
                lcur  = l_addr;
                lpend = BR;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst && !l_empty) lin_pix_q.push_back({l_sof, l_pix});
        end
    end

    task automatic drain(input string tag);
        bit done;
        done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            #2;
            done = !busy && pix_empty && exp_pix_q.size() == 0;
        end
        chk(tag, 64'(done), 64'(1));
        chk({tag, "_addrq"}, 64'(exp_addr_q.size()), 64'(0));
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc0;
        int fp0;
        bit seen;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_mem_req", 64'(mem_req), 64'(0));
        chk("rst_mem_addr", 64'(mem_addr), 64'(0));
        chk("rst_pix_data", 64'(pix_data), 64'(0));
        chk("rst_pix_sof", 64'(pix_sof), 64'(0));
        chk("rst_pix_empty", 64'(pix_empty), 64'(1));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_underrun", 64'(underrun), 64'(0));
        rst = 1'b1;

        // Underrun on an empty FIFO
        repeat (2) @(negedge clk);
        #1 pix_re = 1'b1;
        @(posedge clk);
        #1;
        chk("urun_set", 64'(underrun), 64'(1));
        chk("urun_pix_data", 64'(pix_data), 64'(0));
        chk("urun_empty", 64'(pix_empty), 64'(1));
        repeat (5) @(negedge clk);
        chk("urun_held", 64'(underrun), 64'(1));

        // Trigger latency, back-to-back frames, linear instance in parallel
        cons_mode = 1;
        fp0 = frames_pushed;
        @(negedge clk);
        trigger = 1'b1;
        l_trig  = 1'b1;
        @(posedge clk);
        #1;
        chk("trig_busy", 64'(busy), 64'(1));
        chk("trig_req_c1", 64'(mem_req), 64'(0));
        @(posedge clk);
        #1;
        chk("trig_req_c2", 64'(mem_req), 64'(1));
        chk("trig_addr", 64'(mem_addr), 64'(BASE));
        @(negedge clk);
        l_trig = 1'b0;
        seen = 0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            #2;
            seen = (frames_pushed - fp0) >= 2;
        end
        chk("b2b_second_frame", 64'(seen), 64'(1));
        trigger = 1'b0;
        drain("b2b_drain");
        chk("b2b_frames", 64'(frames_pushed - fp0), 64'(2));
        repeat (20) @(negedge clk);
        chk("b2b_idle_req", 64'(mem_req), 64'(0));

        chk("lin_nreq", 64'(lin_addr_q.size()), 64'(8));
        for (int unsigned k = 0; k < 8 && k < lin_addr_q.size(); k++)
            chk("lin_addr", 64'(lin_addr_q[k]), 64'(24'(BASE + 16 * k)));
        chk("lin_npix", 64'(lin_pix_q.size()), 64'(128));
        for (int unsigned k = 0; k < 128 && k < lin_pix_q.size(); k++)
            chk("lin_pix", 64'(lin_pix_q[k]), 64'(exp_pix(k == 0, 24'(BASE + k))));
        chk("lin_busy", 64'(l_busy), 64'(0));
        chk("lin_underrun", 64'(l_underrun), 64'(1));

        // Back-pressure: FIFO of 32 holds exactly two bursts
        cons_mode = 0;
        rc0 = req_count;
        @(negedge clk) trigger = 1'b1;
        @(negedge clk) trigger = 1'b0;
        repeat (150) @(negedge clk);
        #2;
        chk("bp_nreq", 64'(req_count - rc0), 64'(2));
        chk("bp_req_low", 64'(mem_req), 64'(0));
        chk("bp_nonempty", 64'(pix_empty), 64'(0));
        cons_mode = 3;
        pops_left = 1;
        repeat (30) @(negedge clk);
        #2;
        chk("bp_after1", 64'(req_count - rc0), 64'(2));
        pops_left = 15;
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            #2;
            seen = (req_count - rc0) == 3;
        end
        chk("bp_after16", 64'(req_count - rc0), 64'(3));
        cons_mode = 1;
        drain("bp_drain");

        // Grant delay, valid gaps, stray valids, random pops
        gnt_delay = 5;
        gap_en    = 1;
        spur_en   = 1;
        cons_mode = 2;
        @(negedge clk) trigger = 1'b1;
        @(negedge clk) trigger = 1'b0;
        drain("stall_drain");
        spur_en   = 0;
        gap_en    = 0;
        gnt_delay = 0;
        chk("urun_sticky", 64'(underrun), 64'(1));

        // Reset in the middle of a burst
        cons_mode = 0;
        @(negedge clk) trigger = 1'b1;
        @(negedge clk) trigger = 1'b0;
        seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            #2;
            seen = (beats_done == 7) && (pend > 0);
        end
        chk("mid_beat7", 64'(beats_done), 64'(7));
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("mid_mem_req", 64'(mem_req), 64'(0));
        chk("mid_mem_addr", 64'(mem_addr), 64'(0));
        chk("mid_pix_data", 64'(pix_data), 64'(0));
        chk("mid_pix_sof", 64'(pix_sof), 64'(0));
        chk("mid_pix_empty", 64'(pix_empty), 64'(1));
        chk("mid_busy", 64'(busy), 64'(0));
        chk("mid_underrun", 64'(underrun), 64'(0));
        repeat (2) @(negedge clk);
        exp_addr_q.delete();
        exp_pix_q.delete();
        cons_mode = 1;
        rst = 1'b1;
        trigger = 1'b1;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = mem_req;
        end
        chk("restart_req", 64'(seen), 64'(1));
        chk("restart_addr", 64'(mem_addr), 64'(BASE));
        @(negedge clk) trigger = 1'b0;
        drain("restart_drain");
        chk("final_underrun", 64'(underrun), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
